// File: rtl/axi_pkg.sv
// rtl/axi_pkg.sv - shared AXI constants, burst/response codes and slave FSM state type
package axi_pkg;

  localparam int ID_W   = 4;
  localparam int DATA_W = 32;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  typedef enum logic [1:0] {S_IDLE, S_RD_BURST, S_WR_DATA, S_WR_RESP} state_t;
  typedef enum logic {G_READ, G_WRITE} grant_t;

endpackage

// File: rtl/axi_ram_array.sv
// rtl/axi_ram_array.sv - single-port word RAM with byte write enables and 1-cycle synchronous read
module axi_ram_array #(
  parameter int WORDS_LOG2 = 14
) (
  input  logic                  clk,
  input  logic [WORDS_LOG2-1:0] addr,
  input  logic [3:0]            we,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata
);

  logic [31:0] mem [2**WORDS_LOG2];

  // Contents are deliberately not reset so the RAM survives a bus reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/axi_ram_slave.sv
// rtl/axi_ram_slave.sv - AXI3-style single-outstanding RAM slave for cache refills and stores
module axi_ram_slave
  import axi_pkg::*;
#(
  parameter int          ADDR_BITS = 16,
  parameter logic [31:0] BASE_ADDR = 32'h0,
  parameter logic [7:0]  MAX_LEN   = 8'd15
) (
  input  logic              aclk,
  input  logic              areset,
  input  logic [ID_W-1:0]   arid,
  input  logic [31:0]       araddr,
  input  logic [7:0]        arlen,
  input  logic [2:0]        arsize,
  input  logic [1:0]        arburst,
  input  logic [1:0]        arlock,
  input  logic [3:0]        arcache,
  input  logic [2:0]        arprot,
  input  logic              arvalid,
  output logic              arready,
  output logic [ID_W-1:0]   rid,
  output logic [DATA_W-1:0] rdata,
  output logic [1:0]        rresp,
  output logic              rlast,
  output logic              rvalid,
  input  logic              rready,
  input  logic [ID_W-1:0]   awid,
  input  logic [31:0]       awaddr,
  input  logic [7:0]        awlen,
  input  logic [2:0]        awsize,
  input  logic [1:0]        awburst,
  input  logic [1:0]        awlock,
  input  logic [3:0]        awcache,
  input  logic [2:0]        awprot,
  input  logic              awvalid,
  output logic              awready,
  input  logic [ID_W-1:0]   wid,
  input  logic [DATA_W-1:0] wdata,
  input  logic [3:0]        wstrb,
  input  logic              wlast,
  input  logic              wvalid,
  output logic              wready,
  output logic [ID_W-1:0]   bid,
  output logic [1:0]        bresp,
  output logic              bvalid,
  input  logic              bready
);

  localparam int WA = ADDR_BITS - 2;

  state_t          state;
  grant_t          last_grant;
  logic [ID_W-1:0] id_q;
  logic [WA-1:0]   addr_q;
  logic [7:0]      len_q;
  logic [7:0]      cnt;
  logic [1:0]      burst_q;
  logic            err_q;

  logic            grant_rd, grant_wr, rd_beat, wr_beat;
  logic            ar_err, aw_err;
  logic [WA-1:0]   addr_next, ram_addr;
  logic [3:0]      ram_we;
  logic [31:0]     ram_q;

  logic unused_inputs;
  assign unused_inputs = ^{arsize, awsize, arlock, arcache, arprot, awlock, awcache, awprot,
                           wid, araddr[1:0], awaddr[1:0]};

  // Read wins a simultaneous request only when the previous grant went to write.
  assign grant_rd = (state == S_IDLE) && !areset && arvalid && (!awvalid || last_grant == G_WRITE);
  assign grant_wr = (state == S_IDLE) && !areset && awvalid && !grant_rd;
  assign arready  = grant_rd;
  assign awready  = grant_wr;

  assign rd_beat = (state == S_RD_BURST) && rvalid && rready;
  assign wr_beat = (state == S_WR_DATA) && wvalid && wready;

  assign ar_err = (araddr[31:ADDR_BITS] != BASE_ADDR[31:ADDR_BITS]) || (arlen > MAX_LEN);
  assign aw_err = (awaddr[31:ADDR_BITS] != BASE_ADDR[31:ADDR_BITS]) || (awlen > MAX_LEN);

  // Word index wraps naturally inside the decoded window.
  assign addr_next = (burst_q != BURST_FIXED) ? addr_q + WA'(1) : addr_q;

  // The RAM looks one word ahead so each accepted beat is replaced on the next cycle.
  assign ram_addr = grant_rd ? araddr[ADDR_BITS-1:2] : (rd_beat ? addr_next : addr_q);
  assign ram_we   = (wr_beat && !err_q) ? wstrb : 4'b0000;
  assign rdata    = (rvalid && !err_q) ? ram_q : '0;

  axi_ram_array #(.WORDS_LOG2(WA)) u_ram (
    .clk   (aclk),
    .addr  (ram_addr),
    .we    (ram_we),
    .wdata (wdata),
    .rdata (ram_q)
  );

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state      <= S_IDLE;
      last_grant <= G_WRITE;
      wready     <= 1'b0;
      rvalid     <= 1'b0;
      rlast      <= 1'b0;
      bvalid     <= 1'b0;
      rid        <= '0;
      bid        <= '0;
      rresp      <= RESP_OKAY;
      bresp      <= RESP_OKAY;
      id_q       <= '0;
      addr_q     <= '0;
      len_q      <= '0;
      cnt        <= '0;
      burst_q    <= BURST_FIXED;
      err_q      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (grant_rd) begin
            state      <= S_RD_BURST;
            last_grant <= G_READ;
            rid        <= arid;
            addr_q     <= araddr[ADDR_BITS-1:2];
            len_q      <= arlen;
            burst_q    <= arburst;
            cnt        <= '0;
            err_q      <= ar_err;
            rresp      <= ar_err ? RESP_SLVERR : RESP_OKAY;
            rvalid     <= 1'b1;
            rlast      <= (arlen == 8'd0);
          end else if (grant_wr) begin
            state      <= S_WR_DATA;
            last_grant <= G_WRITE;
            id_q       <= awid;
            addr_q     <= awaddr[ADDR_BITS-1:2];
            len_q      <= awlen;
            burst_q    <= awburst;
            cnt        <= '0;
            err_q      <= aw_err;
            wready     <= 1'b1;
          end
        end
        S_RD_BURST: begin
          if (rd_beat) begin
            if (rlast) begin
              state  <= S_IDLE;
              rvalid <= 1'b0;
              rlast  <= 1'b0;
            end else begin
              cnt    <= cnt + 8'd1;
              addr_q <= addr_next;
              rlast  <= (cnt + 8'd1 == len_q);
            end
          end
        end
        S_WR_DATA: begin
          if (wr_beat) begin
            cnt    <= cnt + 8'd1;
            addr_q <= addr_next;
            // The burst ends on wlast; a beat count that disagrees with awlen is reported.
            if (wlast) begin
              state  <= S_WR_RESP;
              wready <= 1'b0;
              bvalid <= 1'b1;
              bid    <= id_q;
              bresp  <= (err_q || cnt != len_q) ? RESP_SLVERR : RESP_OKAY;
            end
          end
        end
        S_WR_RESP: begin
          if (bready) begin
            bvalid <= 1'b0;
            state  <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
